// File: rtl/program_counter_pkg.sv
// Shared widths, reset value and next-PC select encoding for the fetch-stage program counter.
package program_counter_pkg;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] RST_PC = '0;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_BR   = 2'd2,
    PC_JMP  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: priority decode, incrementer, PC-relative branch adder and 4:1 mux.
module pc_next_mux
  import program_counter_pkg::*;
#(
  parameter int unsigned AW = program_counter_pkg::AW,
  parameter int unsigned DW = program_counter_pkg::DW
) (
  input  logic [AW-1:0] pc_i,
  input  logic          pcEn_i,
  input  logic          jump_i,
  input  logic          branch_i,
  input  logic [DW-1:0] disp_i,
  input  logic [AW-1:0] dSrc_i,
  output logic [AW-1:0] next_pc_o,
  output logic [AW-1:0] pc1_o
);

  pc_sel_e       sel;
  logic [AW-1:0] disp_sext;
  logic [AW-1:0] br_target;

  assign pc1_o     = pc_i + AW'(1);
  assign disp_sext = {{(AW-DW){disp_i[DW-1]}}, disp_i};
  assign br_target = pc1_o + disp_sext;

  // Jump outranks branch; disp and dSrc reach the output only when their select is chosen.
  always_comb begin
    sel = PC_HOLD;
    if (pcEn_i) begin
      if (jump_i)        sel = PC_JMP;
      else if (branch_i) sel = PC_BR;
      else               sel = PC_INC;
    end
  end

  always_comb begin
    next_pc_o = pc_i;
    unique case (sel)
      PC_HOLD: next_pc_o = pc_i;
      PC_INC:  next_pc_o = pc1_o;
      PC_BR:   next_pc_o = br_target;
      PC_JMP:  next_pc_o = dSrc_i;
      default: next_pc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/program_counter.sv
// Fetch-stage program counter: registered pc with synchronous active-low reset, combinational pc+1 link.
module program_counter #(
  parameter int unsigned   AW     = program_counter_pkg::AW,
  parameter int unsigned   DW     = program_counter_pkg::DW,
  parameter logic [AW-1:0] RST_PC = AW'(program_counter_pkg::RST_PC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          branch,
  input  logic          jump,
  input  logic          pcEn,
  input  logic [DW-1:0] disp,
  input  logic [AW-1:0] dSrc,
  output logic [AW-1:0] pc1,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;

  pc_next_mux #(
    .AW(AW),
    .DW(DW)
  ) u_next (
    .pc_i     (pc_q),
    .pcEn_i   (pcEn),
    .jump_i   (jump),
    .branch_i (branch),
    .disp_i   (disp),
    .dSrc_i   (dSrc),
    .next_pc_o(pc_d),
    .pc1_o    (pc1)
  );

  always_ff @(posedge clk) begin
    if (!rst) pc_q <= RST_PC;
    else      pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed scenarios then random traffic against a reference model.
module tb_program_counter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          branch = 1'b0;
  logic          jump = 1'b0;
  logic          pcEn = 1'b0;
  logic [DW-1:0] disp = '0;
  logic [AW-1:0] dSrc = '0;
  logic [AW-1:0] pc1;
  logic [AW-1:0] pc;

  program_counter #(
    .AW    (AW),
    .DW    (DW),
    .RST_PC(16'h0000)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .branch(branch),
    .jump  (jump),
    .pcEn  (pcEn),
    .disp  (disp),
    .dSrc  (dSrc),
    .pc1   (pc1),
    .pc    (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] pc1;
    int            id;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   ref_pc     = 0;
  int   step_id    = 0;
  bit   stim_done  = 1'b0;

  // Reference model: spec rules in plain integer arithmetic modulo 2^16.
  task automatic step(input bit r, input bit en, input bit j, input bit b,
                      input logic [DW-1:0] d, input logic [AW-1:0] s);
    exp_t e;
    int   sd;
    @(negedge clk);
    rst = r; pcEn = en; jump = j; branch = b; disp = d; dSrc = s;
    @(posedge clk);
    sd = (int'(d) >= 128) ? int'(d) - 256 : int'(d);
    if (!r)      ref_pc = 0;
    else if (!en) ref_pc = ref_pc;
    else if (j)  ref_pc = int'(s);
    else if (b)  ref_pc = (ref_pc + 1 + sd + 65536) % 65536;
    else         ref_pc = (ref_pc + 1) % 65536;
    e.pc  = ref_pc[AW-1:0];
    e.pc1 = 16'((ref_pc + 1) % 65536);
    e.id  = step_id;
    step_id++;
    exp_q.push_back(e);
  endtask

  // Monitor: the pc output is refreshed every edge, so compare 1 time unit after each edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (pc !== e.pc || pc1 !== e.pc1) begin
          miscompares++;
          $display("FAIL pc_check step %0d: pc=%h pc1=%h, expected pc=%h pc1=%h",
                   e.id, pc, pc1, e.pc, e.pc1);
        end
      end
    end
  end

  initial begin : stimulus
    int wait_cycles;
    // Reset, then increment
    step(0, 1, 1, 1, 8'h12, 16'h4321);
    step(0, 0, 0, 0, 8'h00, 16'h0000);
    step(1, 1, 0, 0, 8'hAA, 16'hBEEF);
    // Branch forward / back
    step(1, 1, 0, 1, 8'h7F, 16'h0000);
    step(1, 1, 0, 1, 8'hFF, 16'h0000);
    step(1, 1, 0, 1, 8'h80, 16'h0000);
    // Jump beats branch, jump to 0
    step(1, 1, 1, 1, 8'h7F, 16'h8000);
    step(1, 1, 1, 0, 8'h00, 16'h0000);
    // Hold with jump asserted
    step(1, 1, 1, 0, 8'h00, 16'h8000);
    for (int unsigned i = 0; i < 3; i++) step(1, 0, 1, 0, 8'h00, 16'h1234);
    // Wrap / JAL link
    step(1, 1, 1, 0, 8'h00, 16'hFFFF);
    step(1, 1, 0, 0, 8'h00, 16'h0000);
    step(1, 1, 0, 1, 8'h80, 16'h0000);
    // Reset mid-operation
    step(1, 1, 1, 0, 8'h00, 16'h8000);
    step(1, 1, 0, 0, 8'h00, 16'h0000);
    step(0, 1, 1, 0, 8'h00, 16'h5555);
    // Random traffic
    for (int unsigned i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
           DW'($urandom), AW'($urandom));
    end
    stim_done = 1'b1;
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected results never compared, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
